// File: rtl/conv_window_scheduler_if.sv
// Result stream from the window scheduler to the downstream consumer.
// Carries the captured conv result with its output-map coordinates.
interface conv_window_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COORD_W    = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [COORD_W-1:0]    out_row;
  logic [COORD_W-1:0]    out_col;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_row,
    output out_col,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Sequences one shared convolution unit over every output position
// of a feature map, in row-major order, one result per window.
module conv_window_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int F          = 5,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int STRIDE     = 1,
  parameter int COORD_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [COORD_W-1:0]    win_row,
  output logic [COORD_W-1:0]    win_col,
  output logic                  conv_reset,
  input  logic [DATA_WIDTH-1:0] conv_result,
  conv_window_scheduler_if.master stream
);
  localparam int OUT_W       = (IMG_W - F) / STRIDE + 1;
  localparam int OUT_H       = (IMG_H - F) / STRIDE + 1;
  localparam int CONV_CYCLES = D * F * F + 2;
  localparam int CNT_W       = $clog2(CONV_CYCLES);

  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(OUT_H - 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CONV_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    OUT,
    FIN
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [COORD_W-1:0]    row;
  logic [COORD_W-1:0]    col;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  hs;
  logic                  last_win;
  logic                  last_cnt;

  assign hs       = (state == OUT) && valid && stream.out_ready;
  assign last_win = (row == LAST_ROW) && (col == LAST_COL);
  assign last_cnt = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = CLR;
      CLR:  state_n = RUN;
      RUN:  if (last_cnt) state_n = OUT;
      OUT:  if (hs) state_n = last_win ? FIN : CLR;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    conv_reset = 1'b1;
    unique case (state)
      IDLE: busy = 1'b0;
      RUN:  conv_reset = 1'b0;
      FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Coordinates move only on a handshake, so the window stays put through CLR/RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      row   <= '0;
      col   <= '0;
      cnt   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row <= '0;
            col <= '0;
          end
        end
        CLR: cnt <= '0;
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last_cnt) begin
            data  <= conv_result;
            valid <= 1'b1;
          end
        end
        OUT: begin
          if (hs) begin
            valid <= 1'b0;
            if (!last_win) begin
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign win_row = COORD_W'(int'(row) * STRIDE);
  assign win_col = COORD_W'(int'(col) * STRIDE);

  assign stream.out_data  = data;
  assign stream.out_row   = row;
  assign stream.out_col   = col;
  assign stream.out_valid = valid;
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench: two schedulers (5x5 stride 1, 7x7 stride 2, both F=3) in lockstep
// against a behavioural conv unit and a row-major result model.
module tb_conv_window_scheduler;
  localparam int DW     = 16;
  localparam int CW     = 8;
  localparam int NWIN   = 9;
  localparam int OW     = 3;
  localparam int CC     = 11;
  localparam int WINCYC = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic out_ready;

  logic [1:0]         busy;
  logic [1:0]         done;
  logic [1:0]         conv_reset;
  logic [1:0][CW-1:0] win_row;
  logic [1:0][CW-1:0] win_col;
  logic [1:0][DW-1:0] conv_result;
  logic [1:0]         ov;
  logic [1:0][DW-1:0] od;
  logic [1:0][CW-1:0] orow;
  logic [1:0][CW-1:0] ocol;

  conv_window_scheduler_if #(.DATA_WIDTH(DW), .COORD_W(CW)) s0 ();
  conv_window_scheduler_if #(.DATA_WIDTH(DW), .COORD_W(CW)) s1 ();

  assign s0.out_ready = out_ready;
  assign s1.out_ready = out_ready;
  assign ov[0]   = s0.out_valid;
  assign ov[1]   = s1.out_valid;
  assign od[0]   = s0.out_data;
  assign od[1]   = s1.out_data;
  assign orow[0] = s0.out_row;
  assign orow[1] = s1.out_row;
  assign ocol[0] = s0.out_col;
  assign ocol[1] = s1.out_col;

  conv_window_scheduler #(
    .DATA_WIDTH(DW), .D(1), .F(3), .IMG_W(5), .IMG_H(5),
    .STRIDE(1), .COORD_W(CW)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy[0]), .done(done[0]),
    .win_row(win_row[0]), .win_col(win_col[0]),
    .conv_reset(conv_reset[0]), .conv_result(conv_result[0]),
    .stream(s0)
  );

  conv_window_scheduler #(
    .DATA_WIDTH(DW), .D(1), .F(3), .IMG_W(7), .IMG_H(7),
    .STRIDE(2), .COORD_W(CW)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy[1]), .done(done[1]),
    .win_row(win_row[1]), .win_col(win_col[1]),
    .conv_reset(conv_reset[1]), .conv_result(conv_result[1]),
    .stream(s1)
  );

  int errs = 0;
  int checks = 0;
  logic [DW-1:0] key = 16'h1234;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int stride_of(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic [DW-1:0] inc(logic [DW-1:0] kk, int wr,
                                        int wc, int k);
    return DW'(int'(kk) + wr * 131 + wc * 17 + (k + 3) * (wr + wc + 5));
  endfunction

  // Conv unit clears while conv_reset is high; out_data must hold the
  // sum of the first CONV_CYCLES-1 accumulate steps.
  function automatic logic [DW-1:0] exp_data(int i, int r, int c);
    logic [DW-1:0] s = '0;
    for (int k = 0; k < CC - 1; k++)
      s = s + inc(key, r * stride_of(i), c * stride_of(i), k);
    return s;
  endfunction

  logic [1:0][DW-1:0] acc;
  int kcnt [2];
  assign conv_result = acc;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset || conv_reset[i]) begin
        acc[i]  <= '0;
        kcnt[i] <= 0;
      end else begin
        acc[i]  <= acc[i] + inc(key, int'(win_row[i]), int'(win_col[i]),
                                kcnt[i]);
        kcnt[i] <= kcnt[i] + 1;
      end
    end
  end

  int cyc = 0;
  int hs [2];
  int dones [2];
  int stall [2];
  int lowrun [2];
  int last_cyc [2];
  logic [DW-1:0] p_data [2];
  logic [CW-1:0] p_row [2];
  logic [CW-1:0] p_col [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      hs[i] = 0; dones[i] = 0; stall[i] = 0;
      lowrun[i] = 0; last_cyc[i] = 0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        hs[i] = 0; dones[i] = 0; stall[i] = 0; lowrun[i] = 0;
      end else begin
        if (start && !busy[i]) begin
          hs[i] = 0; dones[i] = 0; stall[i] = 0; last_cyc[i] = cyc;
        end
        if (!conv_reset[i]) lowrun[i]++;
        else begin
          if (lowrun[i] != 0) chk("conv_reset_low_run", lowrun[i], CC);
          lowrun[i] = 0;
        end
        if (ov[i] && !out_ready) begin
          if (stall[i] > 0) begin
            chk("stall_data", 32'(od[i]), 32'(p_data[i]));
            chk("stall_row", 32'(orow[i]), 32'(p_row[i]));
            chk("stall_col", 32'(ocol[i]), 32'(p_col[i]));
          end
          chk("stall_conv_reset", 32'(conv_reset[i]), 1);
          p_data[i] = od[i]; p_row[i] = orow[i]; p_col[i] = ocol[i];
          stall[i]++;
        end
        if (ov[i] && out_ready) begin
          if (hs[i] >= NWIN) chk("extra_result", hs[i] + 1, NWIN);
          else begin
            chk("out_row", 32'(orow[i]), hs[i] / OW);
            chk("out_col", 32'(ocol[i]), hs[i] % OW);
            chk("win_row", 32'(win_row[i]), (hs[i] / OW) * stride_of(i));
            chk("win_col", 32'(win_col[i]), (hs[i] % OW) * stride_of(i));
            chk("out_data", 32'(od[i]),
                32'(exp_data(i, hs[i] / OW, hs[i] % OW)));
            chk("result_gap", cyc - last_cyc[i], WINCYC + stall[i]);
          end
          hs[i]++;
          last_cyc[i] = cyc;
          stall[i] = 0;
        end
        if (done[i]) begin
          dones[i]++;
          chk("done_pulses", dones[i], 1);
          chk("done_timing", cyc - last_cyc[i], 1);
          chk("done_results", hs[i], NWIN);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    key = DW'($urandom);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int t = 0;
    while (hs[0] < n && t < 400) begin
      step(1);
      t++;
    end
    chk("wait_hs_timeout", 32'(hs[0] >= n), 1);
  endtask

  task automatic wait_idle_and_count(input string tag);
    int t = 0;
    while (busy[0] && t < 2000) begin
      step(1);
      t++;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_results"}, hs[i], NWIN);
      chk({tag, "_dones"}, dones[i], 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_busy"}, 32'(busy[i]), 0);
      chk({tag, "_done"}, 32'(done[i]), 0);
      chk({tag, "_conv_reset"}, 32'(conv_reset[i]), 1);
      chk({tag, "_win"}, {16'(win_row[i]), 16'(win_col[i])}, 0);
      chk({tag, "_out_valid"}, 32'(ov[i]), 0);
      chk({tag, "_out_rc"}, {16'(orow[i]), 16'(ocol[i])}, 0);
      chk({tag, "_out_data"}, 32'(od[i]), 0);
    end
  endtask

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    step(2);
    check_reset_vals("reset");
    reset = 1'b0;
    step(1);

    // full pass at full rate, then a start that lands on FIN
    pulse_start();
    wait_hs(NWIN);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    chk("start_in_fin_ignored", 32'(busy), 0);
    wait_idle_and_count("full_rate");

    // four-cycle stall on window (1,1)
    pulse_start();
    wait_hs(4);
    out_ready = 1'b0;
    t = 0;
    while (!ov[0] && t < 100) begin
      step(1);
      t++;
    end
    chk("stall_wait_valid", 32'(ov[0]), 1);
    step(4);
    out_ready = 1'b1;
    wait_idle_and_count("stall");

    // start during RUN of window (0,1)
    pulse_start();
    wait_hs(1);
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle_and_count("start_busy");

    // reset during RUN of window (1,0)
    pulse_start();
    wait_hs(3);
    step(5);
    reset = 1'b1;
    step(1);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    step(3);
    chk("mid_reset_no_done", dones[0] + dones[1], 0);
    chk("mid_reset_stays_idle", 32'(busy), 0);
    pulse_start();
    wait_idle_and_count("after_reset");

    // random backpressure
    pulse_start();
    t = 0;
    while (busy[0] && t < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      step(1);
      t++;
    end
    out_ready = 1'b1;
    wait_idle_and_count("random_ready");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
